// File: rtl/bitwise_logic_unit.sv
// Registered WIDTH-bit logic unit: eight selectable bitwise ops, optional accumulator
// operand, and result flags, with valid/ready handshakes and a one-entry output register.
module bitwise_logic_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    input  logic [2:0]       opSel,
    input  logic             useAcc,
    input  logic             loadAcc,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outputC,
    output logic             zeroFlag,
    output logic             onesFlag,
    output logic             parityFlag,
    output logic [WIDTH-1:0] accValue
);

    function automatic logic [WIDTH-1:0] logicOp(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = b;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] accReg;
    logic [WIDTH-1:0] resultReg;
    logic             validReg;
    logic             zeroReg;
    logic             onesReg;
    logic             parityReg;
    logic             accept;
    logic [WIDTH-1:0] opAP0;
    logic [WIDTH-1:0] resultP0;

    // The output register frees up whenever its current contents leave this cycle.
    assign inReady  = !validReg || outReady;
    assign accept   = inValid && inReady;
    assign opAP0    = useAcc ? accReg : inputA;
    assign resultP0 = logicOp(opSel, opAP0, inputB);

    // Stage p0 -> output register
    always_ff @(posedge clk) begin
        if (rst) begin
            validReg  <= 1'b0;
            resultReg <= '0;
            zeroReg   <= 1'b1;
            onesReg   <= 1'b0;
            parityReg <= 1'b0;
            accReg    <= '0;
        end else if (accept) begin
            validReg  <= 1'b1;
            resultReg <= resultP0;
            zeroReg   <= (resultP0 == '0);
            onesReg   <= &resultP0;
            parityReg <= ^resultP0;
            if (loadAcc) begin
                accReg <= resultP0;
            end
        end else if (outReady) begin
            validReg <= 1'b0;
        end
    end

    assign outValid   = validReg;
    assign outputC    = resultReg;
    assign zeroFlag   = zeroReg;
    assign onesFlag   = onesReg;
    assign parityFlag = parityReg;
    assign accValue   = accReg;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: directed scenarios plus randomized
// traffic, all compared against a cycle-level truth-table reference model.
module tb_bitwise_logic_unit;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] inputA;
    logic [W-1:0] inputB;
    logic [2:0]   opSel;
    logic         useAcc;
    logic         loadAcc;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] outputC;
    logic         zeroFlag;
    logic         onesFlag;
    logic         parityFlag;
    logic [W-1:0] accValue;

    bitwise_logic_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .inputA(inputA), .inputB(inputB), .opSel(opSel), .useAcc(useAcc),
        .loadAcc(loadAcc), .outValid(outValid), .outReady(outReady),
        .outputC(outputC), .zeroFlag(zeroFlag), .onesFlag(onesFlag),
        .parityFlag(parityFlag), .accValue(accValue)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: what the block should present after the next rising edge.
    logic         mValid;
    logic [W-1:0] mOut;
    logic [W-1:0] mAcc;
    logic         armed;
    logic         pendConst;
    logic [W-1:0] constVal;
    string        constTag;

    // Truth table per op, indexed by {aBit, bBit}.
    logic [3:0] truth [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] refOp(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [3:0]   tt;
        tt = truth[op];
        for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic checkOutputs();
        int n;
        n = $countones(mOut);
        check("outValid", 32'(outValid), 32'(mValid));
        check("outputC", 32'(outputC), 32'(mOut));
        check("zeroFlag", 32'(zeroFlag), 32'(n == 0));
        check("onesFlag", 32'(onesFlag), 32'(n == W));
        check("parityFlag", 32'(parityFlag), 32'(n % 2));
        check("accValue", 32'(accValue), 32'(mAcc));
        if (pendConst) begin
            check(constTag, 32'(outputC), 32'(constVal));
            pendConst = 1'b0;
        end
    endtask

    // One clock: check state, apply inputs, check inReady, predict next state.
    task automatic drive(input logic r, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op, input logic ua,
                         input logic la, input logic ordy);
        logic         acc;
        logic [W-1:0] res;
        @(negedge clk);
        if (armed) checkOutputs();
        rst = r; inValid = v; inputA = a; inputB = b; opSel = op;
        useAcc = ua; loadAcc = la; outReady = ordy;
        #1;
        if (armed) check("inReady", 32'(inReady), 32'(!mValid || ordy));
        if (r) begin
            mValid = 1'b0; mOut = '0; mAcc = '0;
            armed  = 1'b1;
        end else begin
            acc = v && (!mValid || ordy);
            if (acc) begin
                res    = refOp(op, ua ? mAcc : a, b);
                mOut   = res;
                mValid = 1'b1;
                if (la) mAcc = res;
            end else if (ordy) begin
                mValid = 1'b0;
            end
        end
    endtask

    task automatic expectNext(input string tag, input logic [W-1:0] val);
        pendConst = 1'b1; constTag = tag; constVal = val;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, ordy);
    endtask

    logic [W-1:0] expOps [8];

    initial begin
        truth[0] = 4'b1000; truth[1] = 4'b1110; truth[2] = 4'b0110; truth[3] = 4'b0111;
        truth[4] = 4'b0001; truth[5] = 4'b1001; truth[6] = 4'b0011; truth[7] = 4'b1010;
        expOps[0] = 4'b1000; expOps[1] = 4'b1110; expOps[2] = 4'b0110; expOps[3] = 4'b0111;
        expOps[4] = 4'b0001; expOps[5] = 4'b1001; expOps[6] = 4'b0011; expOps[7] = 4'b1010;
        clk = 0; rst = 1; inValid = 0; inputA = '0; inputB = '0; opSel = '0;
        useAcc = 0; loadAcc = 0; outReady = 0;
        mValid = 0; mOut = '0; mAcc = '0; armed = 0; pendConst = 0; constVal = '0;

        drive(1'b1, 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);

        // All eight ops on A=1100, B=1010, back to back.
        for (int op = 0; op < 8; op++) begin
            drive(1'b0, 1'b1, 4'b1100, 4'b1010, 3'(op), 1'b0, 1'b0, 1'b1);
            expectNext($sformatf("op%0d", op), expOps[op]);
        end
        idle(1'b1);
        idle(1'b1);

        // Backpressure: one result, then 3 stalled cycles with a second request waiting.
        drive(1'b0, 1'b1, 4'h9, 4'h5, 3'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 4'h3, 4'h6, 3'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'h3, 4'h6, 3'd1, 1'b0, 1'b0, 1'b1);
        expectNext("bpSecond", 4'h7);
        idle(1'b1);
        idle(1'b1);

        // Accumulator chain.
        drive(1'b0, 1'b1, 4'hF, 4'hF, 3'd0, 1'b0, 1'b1, 1'b1);
        expectNext("chain0", 4'hF);
        drive(1'b0, 1'b1, 4'h0, 4'h3, 3'd2, 1'b1, 1'b1, 1'b1);
        expectNext("chain1", 4'hC);
        drive(1'b0, 1'b1, 4'h0, 4'h6, 3'd0, 1'b1, 1'b0, 1'b1);
        expectNext("chain2", 4'h4);
        idle(1'b1);
        check("chainAcc", 32'(accValue), 32'h0000000C);
        idle(1'b1);

        // 16 consecutive deliver+accept cycles with distinct results.
        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b1, 4'(i), 4'h0, 3'd1, 1'b0, 1'b0, 1'b1);
        idle(1'b1);

        // Reset in the middle of a stall with a valid result held.
        drive(1'b0, 1'b1, 4'hA, 4'hF, 3'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 4'h1, 4'h1, 3'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'h1, 4'h1, 3'd1, 1'b0, 1'b1, 1'b1);
        idle(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
                  W'($urandom), W'($urandom), 3'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0);
        end
        idle(1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
